// File: rtl/btn_send_arb_pkg.sv
// Shared types and constants for the button-to-DDP send arbiter.
// Holds the handshake state enum, requester geometry, and the round-robin
// search helper used by the top-level arbiter.
package btn_send_arb_pkg;

    localparam int NREQ   = 4;
    localparam int ID_W   = 2;
    localparam int DROP_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } state_e;

    // First pending requester found when searching ptr, ptr+1, ... mod NREQ.
    // Returns ptr when nothing is pending; callers qualify with |pend.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NREQ-1:0] pend,
                                                 input logic [ID_W-1:0] ptr);
        logic [ID_W-1:0] idx;
        logic            found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = ptr + ID_W'(k);
            if (!found && pend[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    // Number of set bits in a requester vector (0..NREQ).
    function automatic logic [2:0] popcount_req(input logic [NREQ-1:0] v);
        popcount_req = 3'd0;
        for (int k = 0; k < NREQ; k++) begin
            popcount_req = popcount_req + {2'b00, v[k]};
        end
    endfunction

endpackage

// File: rtl/btn_send_arb_ack_sync.sv
// Two-flop synchronizer bringing the DDP acknowledge into the clk_i domain.
// Both stages clear to 0 on reset so a reset never looks like an acknowledge.
module ack_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Plain two-stage shift; the first stage may go metastable, the second settles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/btn_send_arb.sv
// Round-robin arbiter and four-phase Send/Ack sequencer between four button
// event sources and the DDP token-injection port. Each granted event becomes
// one packet {ID, SEQ}; SEQ is a per-requester counter.
// Optional feature macro: BTN_SEND_ARB_TIMEOUT_EN -- when defined, a REQ
// that sees no acknowledge for TIMEOUT cycles is abandoned, ERR latches, and
// the same packet (same SEQ) is re-queued for the requester.
module btn_send_arb
    import btn_send_arb_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 1000000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NREQ-1:0]   btn_ev_i,
    input  logic              ack_i,
    output logic              send_o,
    output logic [DATA_W-1:0] data_o,
    output logic              busy_o,
    output logic [DROP_W-1:0] drop_cnt_o,
    output logic              err_o
);

    localparam int SEQ_W = DATA_W - ID_W;

    // Handshake state and registered outputs
    state_e            state_q;
    logic              send_q;
    logic              busy_q;
    logic [DATA_W-1:0] data_q;
    logic [ID_W-1:0]   ptr_q;

    // Requester bookkeeping
    logic [NREQ-1:0]   pend_q;
    logic [NREQ-1:0]   pend_d;
    logic [SEQ_W-1:0]  seq_q [NREQ];
    logic [DROP_W-1:0] drop_cnt_q;
    logic [DROP_W-1:0] drop_cnt_d;
    logic [DROP_W:0]   drop_sum;
    logic [2:0]        drop_n;

    logic              ack_s;
    logic              any_pend;
    logic              grant;
    logic              timeout_hit;
    logic [ID_W-1:0]   win_id;
    logic [ID_W-1:0]   gnt_id;
    logic [NREQ-1:0]   clr_vec;
    logic [NREQ-1:0]   retry_vec;
    logic [NREQ-1:0]   drop_vec;

    ack_sync u_ack_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (ack_i),
        .q_o    (ack_s)
    );

    assign any_pend = |pend_q;
    assign win_id   = rr_pick(pend_q, ptr_q);
    // A new packet is only offered once the DDP has released ACK.
    assign grant    = (state_q == IDLE) && any_pend && !ack_s;
    // The ID of the packet in flight lives in the top bits of DATA.
    assign gnt_id   = data_q[DATA_W-1 -: ID_W];

`ifdef BTN_SEND_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] tmo_cnt_q;
    logic             err_q;

    // An acknowledge arriving on the final cycle still completes normally.
    assign timeout_hit = (state_q == REQ) && !ack_s && (tmo_cnt_q == CNT_W'(TIMEOUT - 1));

    // Count cycles spent in REQ; cleared whenever the FSM is elsewhere.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt_q <= '0;
        end else if (state_q != REQ) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
        end
    end

    // Sticky timeout flag for the ERR LED; only reset clears it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err_o       = 1'b0;
`endif

    // Per-requester pending/clear/drop decisions. A new event beats a
    // same-cycle grant clear, so the requester stays queued.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        assign clr_vec[gi]   = grant && (win_id == ID_W'(gi));
        assign retry_vec[gi] = timeout_hit && (gnt_id == ID_W'(gi));
        assign pend_d[gi]    = btn_ev_i[gi] | retry_vec[gi] | (pend_q[gi] & ~clr_vec[gi]);
        assign drop_vec[gi]  = btn_ev_i[gi] & pend_q[gi] & ~clr_vec[gi];
    end

    // Several requesters can lose an event in the same cycle; add them all and saturate.
    always_comb begin
        drop_n     = popcount_req(drop_vec);
        drop_sum   = {1'b0, drop_cnt_q} + {{(DROP_W - 2){1'b0}}, drop_n};
        drop_cnt_d = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
    end

    // Pending flags, drop counter and sequence numbers. SEQ advances at grant;
    // a timed-out packet restores its SEQ from DATA so the retry reuses it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q     <= '0;
            drop_cnt_q <= '0;
            for (int i = 0; i < NREQ; i++) begin
                seq_q[i] <= '0;
            end
        end else begin
            pend_q     <= pend_d;
            drop_cnt_q <= drop_cnt_d;
            for (int i = 0; i < NREQ; i++) begin
                if (clr_vec[i]) begin
                    seq_q[i] <= seq_q[i] + SEQ_W'(1);
                end else if (retry_vec[i]) begin
                    seq_q[i] <= data_q[SEQ_W-1:0];
                end
            end
        end
    end

    // Handshake FSM: IDLE -> REQ (SEND high) -> REL (wait ACK low) -> IDLE.
    // SEND, DATA and BUSY are registered alongside the state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            send_q  <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= '0;
            ptr_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (grant) begin
                        state_q <= REQ;
                        send_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        data_q  <= {win_id, seq_q[win_id]};
                        ptr_q   <= win_id + ID_W'(1);
                    end
                end
                REQ: begin
                    if (ack_s || timeout_hit) begin
                        state_q <= REL;
                        send_q  <= 1'b0;
                    end
                end
                REL: begin
                    if (!ack_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    send_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign send_o     = send_q;
    assign data_o     = data_q;
    assign busy_o     = busy_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_btn_send_arb.sv
// Self-checking bench for btn_send_arb with a packet-level reference model.
// Uses DATA_W=10 (8-bit SEQ) so sequence wrap is reachable quickly, TIMEOUT=16.
module tb_btn_send_arb;

    localparam int DW  = 10;
    localparam int SW  = DW - 2;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    btn_ev = 4'b0;
    logic          ack = 1'b0;
    logic          send;
    logic [DW-1:0] data;
    logic          busy;
    logic [7:0]    drop_cnt;
    logic          err;

    always #5 clk = ~clk;

    btn_send_arb #(.DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .btn_ev_i   (btn_ev),
        .ack_i      (ack),
        .send_o     (send),
        .data_o     (data),
        .busy_o     (busy),
        .drop_cnt_o (drop_cnt),
        .err_o      (err)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // DDP responder: raises ACK some cycles after seeing SEND, drops it after SEND falls
    bit ack_hold = 1'b0;
    int ack_dly  = 3;
    int rel_dly  = 1;
    int rcnt     = 0;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (ack_hold) begin
                ack  = 1'b0;
                rcnt = 0;
            end else if (!ack) begin
                if (send) begin
                    if (rcnt >= ack_dly) begin ack = 1'b1; rcnt = 0; end
                    else rcnt++;
                end else begin
                    rcnt = 0;
                end
            end else if (!send) begin
                if (rcnt >= rel_dly) begin ack = 1'b0; rcnt = 0; end
                else rcnt++;
            end
        end
    end

    // Reference model: requester queue state expressed as plain arithmetic
    bit [3:0]    m_pend;
    int          m_ptr;
    int          m_seq [4];
    int          m_drop;
    int          m_last_id;
    int          m_last_seq;
    bit          g_seen;
    logic [31:0] g_exp;

    task automatic model_reset();
        m_pend = 4'b0; m_ptr = 0; m_drop = 0; m_last_id = 0; m_last_seq = 0;
        for (int i = 0; i < 4; i++) m_seq[i] = 0;
    endtask

    // One clock edge: optional grant (decided by pending set before the edge),
    // then this cycle's events, then an optional timeout re-queue.
    task automatic model_edge(input logic [3:0] ev, input bit g, input bit tmo);
        int wid;
        bit found;
        if (g) begin
            found = 1'b0;
            wid = 0;
            for (int k = 0; k < 4; k++) begin
                if (!found && m_pend[(m_ptr + k) % 4]) begin
                    found = 1'b1;
                    wid = (m_ptr + k) % 4;
                end
            end
            if (!found) begin
                g_exp = 32'hFFFF_FFFF;
            end else begin
                g_exp = 32'(wid * (1 << SW) + m_seq[wid]);
                m_last_id  = wid;
                m_last_seq = m_seq[wid];
                m_seq[wid] = (m_seq[wid] + 1) % (1 << SW);
                m_ptr = (wid + 1) % 4;
                m_pend[wid] = 1'b0;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (ev[i]) begin
                if (m_pend[i]) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
                m_pend[i] = 1'b1;
            end
        end
        if (tmo) begin
            m_pend[m_last_id] = 1'b1;
            m_seq[m_last_id]  = m_last_seq;
        end
    endtask

    // Apply events for one cycle; observe 1 time unit after the edge.
    task automatic tick(input logic [3:0] ev);
        logic ps;
        ps = send;
        btn_ev = ev;
        @(posedge clk);
        #1;
        btn_ev = 4'b0;
        g_seen = send && !ps;
        model_edge(ev, g_seen, ps && !send && ack_hold);
    endtask

    task automatic apply_reset();
        btn_ev = 4'b0;
        rst_n  = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        n_chk++; if (send !== 1'b0)  $display("FAIL reset_send: got %b want 0", send); else n_pass++;
        n_chk++; if (data !== '0)    $display("FAIL reset_data: got %h want 0", data); else n_pass++;
        n_chk++; if (busy !== 1'b0)  $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_chk++; if (drop_cnt !== 8'd0) $display("FAIL reset_drop: got %0d want 0", drop_cnt); else n_pass++;
        n_chk++; if (err !== 1'b0)   $display("FAIL reset_err: got %b want 0", err); else n_pass++;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        $display("test_reset done");
    endtask

    task automatic test_single();
        int a, f, b, e;
        apply_reset();
        ack_dly = 5; rel_dly = 2;
        tick(4'b0001);
        n_chk++; if (send !== 1'b0) $display("FAIL single_n1_send: got %b want 0", send); else n_pass++;
        tick(4'b0000);
        n_chk++; if (!(g_seen && send === 1'b1)) $display("FAIL single_n2_send: got %b want 1", send); else n_pass++;
        n_chk++; if ({22'd0, data} !== g_exp || data !== 10'h000) $display("FAIL single_data: got %h want %h", data, g_exp); else n_pass++;
        n_chk++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else n_pass++;
        a = -1; f = -1; b = -1; e = -1;
        for (int t = 0; t < 60; t++) begin
            tick(4'b0000);
            if (ack && a < 0) a = t;
            if (a >= 0 && !send && f < 0) f = t;
            if (f >= 0 && !ack && b < 0) b = t;
            if (b >= 0 && !busy && e < 0) e = t;
        end
        n_chk++; if (a < 0 || f - a != 2) $display("FAIL single_ack_to_send_low: got %0d want 2", f - a); else n_pass++;
        n_chk++; if (b < 0 || e - b != 2) $display("FAIL single_ackfall_to_idle: got %0d want 2", e - b); else n_pass++;
        n_chk++; if (drop_cnt !== 8'd0 || busy !== 1'b0) $display("FAIL single_end: got drop %0d busy %b want 0 0", drop_cnt, busy); else n_pass++;
        $display("test_single done");
    endtask

    task automatic test_simultaneous();
        int ng;
        apply_reset();
        ack_dly = 1; rel_dly = 0;
        tick(4'b1111);
        ng = 0;
        for (int t = 0; t < 200 && !(ng == 4 && !busy); t++) begin
            tick(4'b0000);
            if (g_seen) begin
                n_chk++;
                if ({22'd0, data} !== g_exp || {22'd0, data} !== 32'(ng << SW))
                    $display("FAIL simul_pkt%0d: got %h want %h", ng, data, ng << SW);
                else n_pass++;
                ng++;
            end
        end
        n_chk++; if (ng != 4) $display("FAIL simul_count: got %0d want 4", ng); else n_pass++;
        tick(4'b0101);
        ng = 0;
        for (int t = 0; t < 200 && !(ng == 2 && !busy); t++) begin
            tick(4'b0000);
            if (g_seen) begin
                n_chk++;
                if ({22'd0, data} !== g_exp || data !== ((ng == 0) ? 10'h001 : 10'h201))
                    $display("FAIL simul_0101_pkt%0d: got %h want %h", ng, data, g_exp);
                else n_pass++;
                ng++;
            end
        end
        n_chk++; if (ng != 2) $display("FAIL simul_0101_count: got %0d want 2", ng); else n_pass++;
        $display("test_simultaneous done");
    endtask

    task automatic test_drop();
        int ng;
        apply_reset();
        ack_dly = 2; rel_dly = 1; ack_hold = 1'b1;
        tick(4'b0010);
        tick(4'b0000);
        n_chk++; if (!g_seen || data !== 10'h100) $display("FAIL drop_first_pkt: got %h want 100", data); else n_pass++;
        tick(4'b0010); tick(4'b0000); tick(4'b0010); tick(4'b0000); tick(4'b0010);
        n_chk++; if (drop_cnt !== 8'd2 || send !== 1'b1) $display("FAIL drop_cnt: got %0d send %b want 2 1", drop_cnt, send); else n_pass++;
        ack_hold = 1'b0;
        ng = 0;
        for (int t = 0; t < 200 && !(t > 0 && !busy && m_pend == 4'b0); t++) begin
            tick(4'b0000);
            if (g_seen) begin
                n_chk++;
                if ({22'd0, data} !== g_exp || data !== 10'h101) $display("FAIL drop_retry_pkt: got %h want 101", data); else n_pass++;
                ng++;
            end
        end
        n_chk++; if (ng != 1) $display("FAIL drop_pkt_count: got %0d want 1", ng); else n_pass++;
        $display("test_drop done");
    endtask

    task automatic test_wrap();
        int ng;
        apply_reset();
        ack_dly = 0; rel_dly = 0;
        ng = 0;
        for (int t = 0; t < 5000 && ng < (1 << SW) + 1; t++) begin
            tick(4'b1000);
            if (g_seen) begin
                n_chk++;
                if ({22'd0, data} !== g_exp) $display("FAIL wrap_pkt%0d: got %h want %h", ng, data, g_exp); else n_pass++;
                ng++;
            end
        end
        n_chk++; if (ng != (1 << SW) + 1 || data !== 10'h300) $display("FAIL wrap_last: got %h after %0d grants want 300", data, ng); else n_pass++;
        for (int t = 0; t < 100 && !(!busy && m_pend == 4'b0); t++) begin
            tick(4'b0000);
            if (g_seen) begin
                n_chk++;
                if ({22'd0, data} !== g_exp) $display("FAIL wrap_tail: got %h want %h", data, g_exp); else n_pass++;
            end
        end
        n_chk++; if (drop_cnt !== 8'd255 || m_drop != 255) $display("FAIL wrap_drop_sat: got %0d want 255", drop_cnt); else n_pass++;
        $display("test_wrap done");
    endtask

    task automatic test_random();
        logic [3:0] ev;
        int ng;
        apply_reset();
        ng = 0;
        for (int t = 0; t < 800; t++) begin
            for (int i = 0; i < 4; i++) ev[i] = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 15) == 0) begin
                ack_dly = $urandom_range(0, 6);
                rel_dly = $urandom_range(0, 3);
            end
            tick(ev);
            if (g_seen) begin
                ng++;
                n_chk++;
                if ({22'd0, data} !== g_exp) $display("FAIL rand_pkt%0d: got %h want %h", ng, data, g_exp); else n_pass++;
                n_chk++;
                if ({24'd0, drop_cnt} !== 32'(m_drop)) $display("FAIL rand_drop: got %0d want %0d", drop_cnt, m_drop); else n_pass++;
            end
        end
        for (int t = 0; t < 400 && !(!busy && m_pend == 4'b0); t++) begin
            tick(4'b0000);
            if (g_seen) begin
                n_chk++;
                if ({22'd0, data} !== g_exp) $display("FAIL rand_drain: got %h want %h", data, g_exp); else n_pass++;
            end
        end
        n_chk++; if (busy !== 1'b0 || m_pend != 4'b0) $display("FAIL rand_drained: busy %b pend %b want 0 0", busy, m_pend); else n_pass++;
        n_chk++; if ({24'd0, drop_cnt} !== 32'(m_drop) || err !== 1'b0) $display("FAIL rand_end: drop %0d err %b want %0d 0", drop_cnt, err, m_drop); else n_pass++;
        $display("test_random done: %0d packets", ng);
    endtask

`ifdef BTN_SEND_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [DW-1:0] first;
        int nh, ng;
        apply_reset();
        ack_dly = 2; rel_dly = 1; ack_hold = 1'b1;
        tick(4'b0100);
        tick(4'b0000);
        n_chk++; if (!g_seen || data !== 10'h200) $display("FAIL tmo_first: got %h want 200", data); else n_pass++;
        first = data;
        nh = 1;
        for (int t = 0; t < 100; t++) begin
            tick(4'b0000);
            if (!send) break;
            nh++;
        end
        n_chk++; if (nh != TMO) $display("FAIL tmo_send_cycles: got %0d want %0d", nh, TMO); else n_pass++;
        n_chk++; if (err !== 1'b1) $display("FAIL tmo_err: got %b want 1", err); else n_pass++;
        ack_hold = 1'b0;
        ng = 0;
        for (int t = 0; t < 200 && !(ng > 0 && !busy && m_pend == 4'b0); t++) begin
            tick(4'b0000);
            if (g_seen) begin
                n_chk++;
                if (data !== first || {22'd0, data} !== g_exp) $display("FAIL tmo_retry: got %h want %h", data, first); else n_pass++;
                ng++;
            end
        end
        n_chk++; if (ng != 1 || err !== 1'b1) $display("FAIL tmo_end: got %0d retries err %b want 1 1", ng, err); else n_pass++;
        $display("test_timeout done");
    endtask
`endif

    task automatic test_reset_in_req();
        int ns;
        apply_reset();
        ack_dly = 50; rel_dly = 0;
        tick(4'b0010);
        tick(4'b0000);
        n_chk++; if (!g_seen) $display("FAIL rreq_grant: got send %b want 1", send); else n_pass++;
        tick(4'b0001);
        tick(4'b0000);
        #3;
        rst_n = 1'b0;
        #1;
        n_chk++; if (send !== 1'b0 || busy !== 1'b0) $display("FAIL rreq_async: got send %b busy %b want 0 0", send, busy); else n_pass++;
        n_chk++; if (data !== '0 || drop_cnt !== 8'd0 || err !== 1'b0) $display("FAIL rreq_outs: got data %h drop %0d err %b want 0", data, drop_cnt, err); else n_pass++;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        ns = 0;
        for (int t = 0; t < 30; t++) begin
            tick(4'b0000);
            if (send) ns++;
        end
        n_chk++; if (ns != 0) $display("FAIL rreq_no_retry: got %0d send cycles want 0", ns); else n_pass++;
        $display("test_reset_in_req done");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_simultaneous();
        test_drop();
        test_wrap();
        test_random();
`ifdef BTN_SEND_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_in_req();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_chk);
        $fatal(1, "watchdog");
    end

endmodule
